// File: rtl/pc_run_control_pkg.sv
// Shared codes for the PC run-control block: command codes, FSM state codes
// and the default counter/command widths.
package pc_run_control_pkg;

  localparam int CYCLE_COUNTER_SIZE_DEF = 32;
  localparam int CMD_SIZE_DEF           = 2;

  localparam int CMD_RUN   = 0;
  localparam int CMD_STEP  = 1;
  localparam int CMD_STOP  = 2;
  localparam int CMD_CLEAR = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/pc_run_control_cycle_counter.sv
// Saturating executed-cycle counter: counts enabled cycles, clears synchronously,
// and holds at all-ones instead of wrapping.
module pc_run_control_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_run_control.sv
// Debug run-control FSM for the PC/pipeline: RUN/STEP/STOP/CLEAR commands,
// halt detection and an executed-cycle counter. All outputs are registered.
module pc_run_control
  import pc_run_control_pkg::*;
#(
  parameter int CYCLE_COUNTER_SIZE = CYCLE_COUNTER_SIZE_DEF,
  parameter int CMD_SIZE           = CMD_SIZE_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cmd_valid,
  input  logic [CMD_SIZE-1:0]           i_cmd,
  output logic                          o_cmd_ready,
  input  logic                          i_halt_detected,
  output logic                          o_pc_start,
  output logic                          o_pc_enable,
  output logic                          o_pc_halt,
  output logic                          o_done,
  output logic [CYCLE_COUNTER_SIZE-1:0] o_cycle_count,
  output logic [1:0]                    o_state
);

  state_t r_state, w_state_next;
  logic   r_start, w_start_next;
  logic   r_enable, w_enable_next;
  logic   r_halt, w_halt_next;
  logic   r_done, w_done_next;
  logic   r_step, w_step_next;
  logic   r_ready;

  logic w_cmd_acc, w_is_run, w_is_step, w_is_stop, w_is_clear, w_count_clear;

  assign w_cmd_acc  = i_cmd_valid && r_ready;
  assign w_is_run   = w_cmd_acc && (i_cmd == CMD_SIZE'(CMD_RUN));
  assign w_is_step  = w_cmd_acc && (i_cmd == CMD_SIZE'(CMD_STEP));
  assign w_is_stop  = w_cmd_acc && (i_cmd == CMD_SIZE'(CMD_STOP));
  assign w_is_clear = w_cmd_acc && (i_cmd == CMD_SIZE'(CMD_CLEAR));

  always_comb begin
    w_state_next  = r_state;
    w_start_next  = 1'b0;
    w_enable_next = 1'b0;
    w_halt_next   = 1'b0;
    w_done_next   = 1'b0;
    w_step_next   = 1'b0;
    if (w_is_clear) begin
      w_state_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_is_run) begin
            w_state_next  = ST_RUN;
            w_start_next  = 1'b1;
            w_enable_next = 1'b1;
          end else if (w_is_step) begin
            w_state_next  = ST_PAUSED;
            w_start_next  = 1'b1;
            w_enable_next = 1'b1;
            w_step_next   = 1'b1;
          end
        end
        ST_RUN: begin
          // Halt takes priority over a STOP arriving in the same cycle.
          if (i_halt_detected) begin
            w_state_next = ST_HALTED;
            w_halt_next  = 1'b1;
            w_done_next  = 1'b1;
          end else if (w_is_stop) begin
            w_state_next = ST_PAUSED;
          end else begin
            w_enable_next = 1'b1;
          end
        end
        ST_PAUSED: begin
          // r_step marks the single step-enable cycle; commands are blocked then.
          if (r_step) begin
            if (i_halt_detected) begin
              w_state_next = ST_HALTED;
              w_halt_next  = 1'b1;
              w_done_next  = 1'b1;
            end
          end else if (w_is_run) begin
            w_state_next  = ST_RUN;
            w_enable_next = 1'b1;
          end else if (w_is_step) begin
            w_enable_next = 1'b1;
            w_step_next   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_start  <= 1'b0;
      r_enable <= 1'b0;
      r_halt   <= 1'b0;
      r_done   <= 1'b0;
      r_step   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_start  <= w_start_next;
      r_enable <= w_enable_next;
      r_halt   <= w_halt_next;
      r_done   <= w_done_next;
      r_step   <= w_step_next;
      r_ready  <= !w_step_next;
    end
  end

  assign w_count_clear = i_reset || w_is_clear;

  pc_run_control_cycle_counter #(
    .WIDTH(CYCLE_COUNTER_SIZE)
  ) u_cycle_counter (
    .i_clk   (i_clk),
    .i_clear (w_count_clear),
    .i_enable(r_enable),
    .o_count (o_cycle_count)
  );

  assign o_cmd_ready = r_ready;
  assign o_pc_start  = r_start;
  assign o_pc_enable = r_enable;
  assign o_pc_halt   = r_halt;
  assign o_done      = r_done;
  assign o_state     = r_state;

endmodule

// File: tb/tb_pc_run_control.sv
// Directed scoreboard bench for pc_run_control: each step queues the expected
// post-edge outputs, then pops and compares them after the clock edge.
module tb_pc_run_control;

  localparam logic [1:0] CR = 2'd0, CS = 2'd1, CP = 2'd2, CC = 2'd3;
  localparam logic [1:0] SI = 2'd0, SR = 2'd1, SP = 2'd2, SH = 2'd3;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd = 2'd0;
  logic        i_halt_detected = 1'b0;
  logic        o_cmd_ready, o_pc_start, o_pc_enable, o_pc_halt, o_done;
  logic [31:0] o_cycle_count;
  logic [1:0]  o_state;
  logic        s_cmd_ready, s_pc_start, s_pc_enable, s_pc_halt, s_done;
  logic [2:0]  s_cycle_count;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  pc_run_control u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt_detected(i_halt_detected),
    .o_pc_start(o_pc_start), .o_pc_enable(o_pc_enable), .o_pc_halt(o_pc_halt),
    .o_done(o_done), .o_cycle_count(o_cycle_count), .o_state(o_state)
  );

  // Narrow-counter copy used only to observe saturation.
  pc_run_control #(.CYCLE_COUNTER_SIZE(3)) u_sat (
    .i_clk(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(s_cmd_ready), .i_halt_detected(i_halt_detected),
    .o_pc_start(s_pc_start), .o_pc_enable(s_pc_enable), .o_pc_halt(s_pc_halt),
    .o_done(s_done), .o_cycle_count(s_cycle_count), .o_state(s_state)
  );

  typedef struct {
    string       tag;
    logic [6:0]  flags;   // {state, start, enable, halt, done, ready}
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_pop();
    exp_t       e;
    logic [6:0] obs;
    e   = sb_q.pop_front();
    obs = {o_state, o_pc_start, o_pc_enable, o_pc_halt, o_done, o_cmd_ready};
    n_cmp++;
    assert (obs === e.flags) else begin
      n_err++;
      $error("FAIL %s flags{st,start,en,halt,done,rdy} observed=%b expected=%b", e.tag, obs, e.flags);
    end
    n_cmp++;
    assert (o_cycle_count === e.cnt) else begin
      n_err++;
      $error("FAIL %s cycle_count observed=%0d expected=%0d", e.tag, o_cycle_count, e.cnt);
    end
    n_cmp++;
    assert ((o_pc_start & o_pc_halt) === 1'b0) else begin
      n_err++;
      $error("FAIL %s start_and_halt observed=%b expected=0", e.tag, o_pc_start & o_pc_halt);
    end
  endtask

  task automatic st(input string tag, input logic rst, input logic vld, input logic [1:0] cmd,
                    input logic hlt_in, input logic [1:0] est, input logic estart, input logic een,
                    input logic ehalt, input logic edone, input logic erdy, input int ecnt);
    exp_t e;
    @(negedge clk);
    i_reset = rst; i_cmd_valid = vld; i_cmd = cmd; i_halt_detected = hlt_in;
    e.tag = tag; e.flags = {est, estart, een, ehalt, edone, erdy}; e.cnt = 32'(ecnt);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    // Reset for 5 cycles, then RUN for 10 enable cycles, STOP.
    for (int j = 0; j < 5; j++) st("reset", 1, 0, CR, 0, SI, 0, 0, 0, 0, 1, 0);
    st("idle", 0, 0, CR, 0, SI, 0, 0, 0, 0, 1, 0);
    st("run_accept", 0, 1, CR, 0, SR, 1, 1, 0, 0, 1, 0);
    for (int j = 1; j <= 9; j++) st("running", 0, 0, CR, 0, SR, 0, 1, 0, 0, 1, j);
    st("stop", 0, 1, CP, 0, SP, 0, 0, 0, 0, 1, 10);
    n_cmp++;
    assert (s_cycle_count === 3'd7) else begin
      n_err++;
      $error("FAIL saturate observed=%0d expected=7", s_cycle_count);
    end

    // Three single steps from PAUSED; a command during the step cycle is dropped.
    st("step1", 0, 1, CS, 0, SP, 0, 1, 0, 0, 0, 10);
    st("step1_blocked_run", 0, 1, CR, 0, SP, 0, 0, 0, 0, 1, 11);
    st("step2", 0, 1, CS, 0, SP, 0, 1, 0, 0, 0, 11);
    st("step2_end", 0, 0, CR, 0, SP, 0, 0, 0, 0, 1, 12);
    st("step3", 0, 1, CS, 0, SP, 0, 1, 0, 0, 0, 12);
    st("step3_end", 0, 0, CR, 0, SP, 0, 0, 0, 0, 1, 13);
    st("paused_stop_noop", 0, 1, CP, 0, SP, 0, 0, 0, 0, 1, 13);
    st("paused_halt_ignored", 0, 0, CR, 1, SP, 0, 0, 0, 0, 1, 13);

    // RUN, halt after 7 enable cycles, then commands are no-ops in HALTED.
    st("resume", 0, 1, CR, 0, SR, 0, 1, 0, 0, 1, 13);
    for (int j = 14; j <= 19; j++) st("running2", 0, 0, CR, 0, SR, 0, 1, 0, 0, 1, j);
    st("halt", 0, 0, CR, 1, SH, 0, 0, 1, 1, 1, 20);
    st("halted", 0, 0, CR, 0, SH, 0, 0, 0, 0, 1, 20);
    st("halted_run", 0, 1, CR, 0, SH, 0, 0, 0, 0, 1, 20);
    st("halted_step", 0, 1, CS, 0, SH, 0, 0, 0, 0, 1, 20);
    st("halted_stop", 0, 1, CP, 0, SH, 0, 0, 0, 0, 1, 20);

    // CLEAR from HALTED, then STEP from IDLE.
    st("clear", 0, 1, CC, 0, SI, 0, 0, 0, 0, 1, 0);
    st("idle_step", 0, 1, CS, 0, SP, 1, 1, 0, 0, 0, 0);
    st("idle_step_end", 0, 0, CR, 0, SP, 0, 0, 0, 0, 1, 1);

    // STOP and halt together in RUN: halt wins.
    st("run_again", 0, 1, CR, 0, SR, 0, 1, 0, 0, 1, 1);
    st("run_again2", 0, 0, CR, 0, SR, 0, 1, 0, 0, 1, 2);
    st("stop_and_halt", 0, 1, CP, 1, SH, 0, 0, 1, 1, 1, 3);
    st("after_stop_halt", 0, 0, CR, 0, SH, 0, 0, 0, 0, 1, 3);

    // Halt during a step-enable cycle goes to HALTED.
    st("clear2", 0, 1, CC, 0, SI, 0, 0, 0, 0, 1, 0);
    st("step_then_halt", 0, 1, CS, 0, SP, 1, 1, 0, 0, 0, 0);
    st("halt_in_step", 0, 0, CR, 1, SH, 0, 0, 1, 1, 1, 1);
    st("after_step_halt", 0, 0, CR, 0, SH, 0, 0, 0, 0, 1, 1);

    // Reset mid-RUN at count 4 with a pending command.
    st("clear3", 0, 1, CC, 0, SI, 0, 0, 0, 0, 1, 0);
    st("run3", 0, 1, CR, 0, SR, 1, 1, 0, 0, 1, 0);
    for (int j = 1; j <= 4; j++) st("running3", 0, 0, CR, 0, SR, 0, 1, 0, 0, 1, j);
    st("reset_mid_run", 1, 1, CP, 0, SI, 0, 0, 0, 0, 1, 0);
    st("reset_release", 0, 0, CR, 0, SI, 0, 0, 0, 0, 1, 0);
    st("idle_halt_ignored", 0, 0, CR, 1, SI, 0, 0, 0, 0, 1, 0);

    // Reset during a step-enable cycle, and CLEAR straight out of RUN.
    st("step4", 0, 1, CS, 0, SP, 1, 1, 0, 0, 0, 0);
    st("reset_mid_step", 1, 0, CR, 0, SI, 0, 0, 0, 0, 1, 0);
    st("run4", 0, 1, CR, 0, SR, 1, 1, 0, 0, 1, 0);
    st("run4b", 0, 0, CR, 0, SR, 0, 1, 0, 0, 1, 1);
    st("clear_in_run", 0, 1, CC, 0, SI, 0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_run_control.md
PC_RUN_CONTROL -- requirements
Module: pc_run_control

Interface
REQ-001 Parameter CYCLE_COUNTER_SIZE, default 32, width of the executed-cycle counter.
REQ-002 Parameter CMD_SIZE, default 2, width of the command code.
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_reset  input  1  synchronous, active-high reset.
REQ-005 i_cmd_valid  input  1  debug command present.
REQ-006 i_cmd  input  CMD_SIZE  command code: RUN=0, STEP=1, STOP=2, CLEAR=3.
REQ-007 o_cmd_ready  output  1  command accepted when i_cmd_valid && o_cmd_ready at a rising edge.
REQ-008 i_halt_detected  input  1  HALT instruction reached write-back; level, sampled each edge.
REQ-009 o_pc_start  output  1  one-cycle start pulse to the PC.
REQ-010 o_pc_enable  output  1  PC/pipeline advance enable.
REQ-011 o_pc_halt  output  1  one-cycle halt pulse to the PC.
REQ-012 o_done  output  1  one-cycle pulse on entry to HALTED.
REQ-013 o_cycle_count  output  CYCLE_COUNTER_SIZE  number of cycles with o_pc_enable=1 since last CLEAR/reset.
REQ-014 o_state  output  2  current FSM state code.

Function
REQ-015 FSM states SHALL be IDLE=0, RUN=1, PAUSED=2, HALTED=3; all outputs registered.
REQ-016 IDLE: enable=0; RUN accepted -> next cycle o_pc_start=1 and o_pc_enable=1, state RUN.
REQ-017 IDLE: STEP accepted -> next cycle o_pc_start=1 and o_pc_enable=1 for exactly one cycle, then state PAUSED.
REQ-018 RUN: o_pc_enable=1 every cycle; STOP accepted -> o_pc_enable=0 from next cycle, state PAUSED.
REQ-019 RUN: i_halt_detected=1 -> next cycle o_pc_enable=0, o_pc_halt=1, o_done=1 (both one cycle), state HALTED.
REQ-020 PAUSED: enable=0; RUN accepted -> RUN without start pulse; STEP accepted -> o_pc_enable=1 for exactly one cycle, stay PAUSED; STOP accepted as no-op.
REQ-021 HALTED: enable=0; RUN, STEP, STOP accepted as no-ops; only CLEAR leaves HALTED.
REQ-022 CLEAR accepted in any state -> next cycle state IDLE, all control outputs 0, o_cycle_count=0.
REQ-023 o_cmd_ready SHALL be 1 except during the single step-enable cycle, when it is 0.
REQ-024 o_cycle_count increments by 1 for each cycle o_pc_enable=1; saturates at all-ones, no wrap.
REQ-025 i_halt_detected and an accepted STOP in the same RUN cycle: halt wins, state HALTED.
REQ-026 i_halt_detected during a step-enable cycle -> HALTED with halt/done pulses, not PAUSED.
REQ-027 i_halt_detected in IDLE or PAUSED is ignored.
REQ-028 o_pc_start and o_pc_halt SHALL never be 1 in the same cycle.

Reset
REQ-029 i_reset=1 at an edge -> state IDLE, o_pc_start=0, o_pc_enable=0, o_pc_halt=0, o_done=0, o_cycle_count=0, o_cmd_ready=1.
REQ-030 Reset mid-RUN or mid-step SHALL drop o_pc_enable in the cycle after the edge; no pulse emitted; pending command discarded.

Structure
REQ-031 Command codes, state codes and CYCLE_COUNTER_SIZE default belong in the shared MIPS header included by mips/if sources and benches.
REQ-032 Single flat module; the saturating counter may be one sub-module, cycle_counter, with enable/clear inputs.

Verification
REQ-033 Reset 5 cycles, RUN, 10 cycles, STOP -> one start pulse, o_cycle_count=10 (±accept-edge alignment fixed to exactly 10), state PAUSED.
REQ-034 From PAUSED, 3 STEP commands -> exactly 3 single-cycle enables, o_cmd_ready low in each, o_cycle_count=13, no start pulse.
REQ-035 RUN, then i_halt_detected=1 after 7 enable cycles -> o_pc_halt and o_done pulse once, state HALTED, count frozen at 20; further RUN/STEP leave count 20.
REQ-036 STOP and i_halt_detected same cycle in RUN -> state HALTED, o_pc_halt=1 one cycle.
REQ-037 CLEAR from HALTED -> state IDLE, o_cycle_count=0; then STEP -> start+enable one cycle, count=1, PAUSED.
REQ-038 i_reset asserted mid-RUN at count 4 -> next cycle enable=0, count=0, IDLE, no halt/done pulse.
